// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
package fetch_unit_pkg;

   // Fetch FSM states.
   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      FLUSH
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Clear the byte-offset bits so every fetch address is word-aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit. One request is issued per
// instruction; the returned word is held for decode until it is accepted.
// A redirect always wins and never lets a wrong-path word reach decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  ipc_q, ipc_d;

   // State, fetch pc and the instruction buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= align_pc(RESET_PC);
         inst_q  <= NOP_INST;
         ipc_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
      end
   end

   // Next-state, pc update and handshake outputs.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      inst_d         = inst_q;
      ipc_d          = ipc_q;
      imem_req_valid = 1'b0;
      if_valid       = 1'b0;

      // A redirect updates pc in every state.
      if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end

      unique case (state_q)
         IDLE: begin
            state_d = REQ;
         end

         REQ: begin
            imem_req_valid = 1'b1;
            if (redirect_valid) begin
               // An accepted request still owes a response that must be dropped.
               state_d = imem_req_ready ? FLUSH : REQ;
            end else if (imem_req_ready) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (redirect_valid) begin
               // Same-cycle response is the stale one: discard it and refetch.
               state_d = imem_rsp_valid ? REQ : FLUSH;
            end else if (imem_rsp_valid) begin
               inst_d  = imem_rsp_data;
               ipc_d   = pc_q;
               pc_d    = pc_q + 32'd4;
               state_d = HOLD;
            end
         end

         HOLD: begin
            // Redirect masks the held word combinationally in the same cycle.
            if_valid = ~redirect_valid;
            if (redirect_valid || if_ready) begin
               state_d = REQ;
            end
         end

         FLUSH: begin
            // The outstanding response is consumed even if a new redirect
            // arrives with it; otherwise stay and keep waiting for it.
            if (imem_rsp_valid) begin
               state_d = REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign imem_req_addr = pc_q;
   assign if_inst       = inst_q;
   assign if_pc         = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task walks the FSM through one scenario
// with hand-computed expectations.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;

   int total = 0;
   int bad   = 0;

   fetch_unit #(
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_inst       (if_inst),
      .if_pc         (if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responses are only legal while a request is outstanding.
   always @(posedge clk) begin
      if (!rst && imem_rsp_valid &&
          (dut.state_q == IDLE || dut.state_q == REQ || dut.state_q == HOLD)) begin
         bad = bad + 1;
         $display("FAIL rsp_protocol: response in state %0d, required WAIT or FLUSH",
                  dut.state_q);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next falling edge.
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      nxt();
      nxt();
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valids: req=%b if=%b required 0 0", imem_req_valid, if_valid);
      end
      total++;
      if (if_inst !== 32'h0000_0013 || if_pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_regs: inst=%h pc=%h required 00000013 00000000", if_inst, if_pc);
      end
      rst = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_req: got %b required 0", imem_req_valid);
      end
   endtask

   task automatic test_first_fetch();
      nxt();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         bad++;
         $display("FAIL first_req: valid=%b addr=%h required 1 00000000",
                  imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL wait_outputs: req=%b if=%b required 0 0", imem_req_valid, if_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0093;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0010_0093) begin
         bad++;
         $display("FAIL first_hold: v=%b pc=%h inst=%h required 1 00000000 00100093",
                  if_valid, if_pc, if_inst);
      end
      if_ready = 1'b1;
      nxt();
      if_ready = 1'b0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
         bad++;
         $display("FAIL second_req: valid=%b addr=%h required 1 00000004",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_req_stall();
      for (int i = 0; i < 5; i++) begin
         nxt();
         total++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
            bad++;
            $display("FAIL req_stall[%0d]: valid=%b addr=%h required 1 00000004",
                     i, imem_req_valid, imem_req_addr);
         end
      end
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0020_0113;
      nxt();
      imem_rsp_valid = 1'b0;
   endtask

   task automatic test_hold_stall();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (if_valid !== 1'b1 || if_inst !== 32'h0020_0113 || if_pc !== 32'h4 ||
             imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_stall[%0d]: v=%b inst=%h pc=%h req=%b required 1 00200113 00000004 0",
                     i, if_valid, if_inst, if_pc, imem_req_valid);
         end
         if (i < 4) nxt();
      end
      if_ready = 1'b1;
      nxt();
      if_ready = 1'b0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
         bad++;
         $display("FAIL after_hold_req: valid=%b addr=%h required 1 00000008",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      nxt();
      redirect_valid = 1'b0;
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush1: req=%b if=%b required 0 0", imem_req_valid, if_valid);
      end
      nxt();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0001;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
         bad++;
         $display("FAIL redirect_wait_req: if=%b req=%b addr=%h required 0 1 00000100",
                  if_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0030_0193;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h0030_0193) begin
         bad++;
         $display("FAIL redirect_wait_hold: v=%b pc=%h inst=%h required 1 00000100 00300193",
                  if_valid, if_pc, if_inst);
      end
      if_ready = 1'b1;
      nxt();
      if_ready = 1'b0;
   endtask

   task automatic test_redirect_handshake();
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      nxt();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL hs_flush: req=%b if=%b required 0 0", imem_req_valid, if_valid);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0002;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         bad++;
         $display("FAIL hs_refetch: if=%b req=%b addr=%h required 0 1 00000200",
                  if_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0040_0213;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== 32'h0040_0213) begin
         bad++;
         $display("FAIL hs_hold: v=%b pc=%h inst=%h required 1 00000200 00400213",
                  if_valid, if_pc, if_inst);
      end
   endtask

   task automatic test_redirect_hold();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      #1;
      total++;
      if (if_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_mask: if_valid=%b required 0", if_valid);
      end
      nxt();
      redirect_valid = 1'b0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
         bad++;
         $display("FAIL hold_redirect_req: valid=%b addr=%h required 1 00000300",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_req();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_040E;
      nxt();
      redirect_valid = 1'b0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40C) begin
         bad++;
         $display("FAIL req_redirect: valid=%b addr=%h required 1 0000040c",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_rsp();
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_0003;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0500;
      nxt();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin
         bad++;
         $display("FAIL rsp_redirect: if=%b req=%b addr=%h required 0 1 00000500",
                  if_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      nxt();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0293;
      nxt();
      imem_rsp_valid = 1'b0;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
         bad++;
         $display("FAIL wrap_hold: v=%b pc=%h required 1 fffffffc", if_valid, if_pc);
      end
      if_ready = 1'b1;
      nxt();
      if_ready = 1'b0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         bad++;
         $display("FAIL wrap_req: valid=%b addr=%h required 1 00000000",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset_mid();
      imem_req_ready = 1'b1;
      nxt();
      imem_req_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 ||
          if_inst !== 32'h0000_0013) begin
         bad++;
         $display("FAIL mid_reset: req=%b if=%b pc=%h inst=%h required 0 0 00000000 00000013",
                  imem_req_valid, if_valid, if_pc, if_inst);
      end
      nxt();
      rst = 1'b0;
      #1;
      nxt();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_req: valid=%b addr=%h required 1 00000000",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;

      test_reset();
      test_first_fetch();
      test_req_stall();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_handshake();
      test_redirect_hold();
      test_redirect_req();
      test_redirect_rsp();
      test_wrap();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts the request.
REQ-006 imem_req_addr  output  32  fetch byte address, always word-aligned.
REQ-007 imem_rsp_valid  input  1  response data valid; one response per accepted request, at least one cycle after acceptance.
REQ-008 imem_rsp_data  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 if_valid  output  1  instruction offered to decode.
REQ-012 if_ready  input  1  decode accepts the instruction.
REQ-013 if_inst  output  32  instruction word to decode.
REQ-014 if_pc  output  32  address of if_inst.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and FLUSH, with at most one outstanding memory request.
REQ-016 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-017 REQ: imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready go to WAIT.
REQ-018 WAIT: on imem_rsp_valid, latch if_inst<=imem_rsp_data and if_pc<=pc, set pc<=pc+4 (mod 2^32), and go to HOLD.
REQ-019 HOLD: if_valid=1; on if_ready go to REQ, giving a minimum of 3 cycles per instruction with single-cycle memory.
REQ-020 if_inst and if_pc SHALL stay stable while in HOLD and not accepted.
REQ-021 Redirect SHALL take priority over every other event, load pc<=redirect_pc with bits [1:0] forced to 0, and never present a wrong-path instruction.
REQ-022 Redirect in REQ without handshake: stay in REQ at the new pc; imem_req_addr may change only in this case.
REQ-023 Redirect in REQ with handshake in the same cycle: go to FLUSH.
REQ-024 Redirect in WAIT without rsp_valid: go to FLUSH.
REQ-025 Redirect in WAIT with rsp_valid in the same cycle: discard the data and go to REQ.
REQ-026 FLUSH: discard the next response, then go to REQ; a redirect in FLUSH updates pc and stays in FLUSH.
REQ-027 Redirect in HOLD: drop the held instruction, force if_valid=0 that cycle combinationally, and go to REQ.
REQ-028 imem_req_valid=0 in IDLE, WAIT, HOLD and FLUSH; if_valid=0 outside HOLD.
REQ-029 imem_rsp_valid in REQ, IDLE or HOLD SHALL be ignored; a bench assertion SHALL flag it.

Reset
REQ-030 On rst: state=IDLE, pc=RESET_PC, if_inst=32'h0000_0013 (NOP), if_pc=0, imem_req_valid=0, if_valid=0.
REQ-031 Reset asserted mid-request SHALL abandon the transaction; the memory is reset by the same rst.

Structure
REQ-032 The enum fetch_state_e (IDLE, REQ, WAIT, HOLD, FLUSH) and the constant NOP_INST SHALL be added to the shared types package.
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Reset release with RESET_PC=0, ready=1, 1-cycle response -> request at 0x0 in the first REQ cycle; if_valid with if_pc=0x0 two edges later; next request at 0x4.
REQ-035 Hold imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays stable.
REQ-036 Hold if_ready=0 for 4 cycles in HOLD -> if_inst/if_pc unchanged; no new request issued.
REQ-037 Redirect to 0x103 while in WAIT, response 2 cycles later -> response discarded, next request at 0x100, first if_pc=0x100.
REQ-038 Redirect in the same cycle as the request handshake -> FLUSH entered, one response dropped, refetch at the target.
REQ-039 pc=0xFFFF_FFFC fetched -> next request address 0x0000_0000.
